// File: rtl/n1_irq_ctrl.sv
// ============================================================================
// n1_irq_ctrl : edge/level interrupt latch, mask, fixed-priority select and
//               ISR-address request for N1, configured over a Wishbone slave.
//               Optional IRQ_SYNC_EN adds a 2-flop input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module n1_irq_ctrl #(
  parameter int IRQ_CNT = 8
) (
  input  logic               clk_i,
  input  logic               async_rst_i,
  input  logic [IRQ_CNT-1:0] irq_i,
  output logic [15:0]        irq_req_o,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_adr_i,
  input  logic [15:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [15:0]        wbs_dat_o
);

  logic [IRQ_CNT-1:0] irq_s;
  logic [IRQ_CNT-1:0] prev_q;
  logic [IRQ_CNT-1:0] pend_q, pend_d;
  logic [IRQ_CNT-1:0] ena_q, ena_d;
  logic [IRQ_CNT-1:0] edge_q, edge_d;
  logic [15:0]        vec_q [IRQ_CNT];
  logic [15:0]        vec_d [IRQ_CNT];
  logic [15:0]        req_q, req_d;
  logic               ack_q;
  logic [15:0]        dat_q, dat_d;

  logic               access, wr, rd;
  logic [IRQ_CNT-1:0] w1c, rise, req;
  logic [15:0]        rdata;

`ifdef IRQ_SYNC_EN
  logic [IRQ_CNT-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_i;
`endif

  // One access per two cycles: a new access is only accepted while ack is low.
  assign access = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr     = access & wbs_we_i;
  assign rd     = access & ~wbs_we_i;
  assign w1c    = (wr && wbs_adr_i == 4'd0) ? wbs_dat_i[IRQ_CNT-1:0] : '0;
  assign rise   = irq_s & ~prev_q;
  assign req    = pend_q & ena_q;

  // Edge lines: a new rising edge beats a simultaneous W1C of the same bit.
  always_comb begin
    pend_d = (edge_q & ((pend_q & ~w1c) | rise)) | (~edge_q & irq_s);
    ena_d  = ena_q;
    edge_d = edge_q;
    vec_d  = vec_q;
    if (wr && wbs_adr_i == 4'd1) ena_d  = wbs_dat_i[IRQ_CNT-1:0];
    if (wr && wbs_adr_i == 4'd2) edge_d = wbs_dat_i[IRQ_CNT-1:0];
    for (int n = 0; n < IRQ_CNT; n++) begin
      if (wr && wbs_adr_i == 4'(8 + n)) vec_d[n] = wbs_dat_i;
    end
  end

  always_comb begin
    rdata = '0;
    case (wbs_adr_i)
      4'd0:    rdata[IRQ_CNT-1:0] = pend_q;
      4'd1:    rdata[IRQ_CNT-1:0] = ena_q;
      4'd2:    rdata[IRQ_CNT-1:0] = edge_q;
      default: begin
        for (int n = 0; n < IRQ_CNT; n++) begin
          if (wbs_adr_i == 4'(8 + n)) rdata = vec_q[n];
        end
      end
    endcase
    dat_d = rd ? rdata : '0;
  end

  // Descending scan so the lowest-indexed requesting line is written last.
  always_comb begin
    req_d = '0;
    for (int n = IRQ_CNT - 1; n >= 0; n--) begin
      if (req[n]) req_d = vec_q[n];
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      prev_q <= '0;
      pend_q <= '0;
      ena_q  <= '0;
      edge_q <= '0;
      for (int n = 0; n < IRQ_CNT; n++) vec_q[n] <= '0;
      req_q  <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      prev_q <= irq_s;
      pend_q <= pend_d;
      ena_q  <= ena_d;
      edge_q <= edge_d;
      vec_q  <= vec_d;
      req_q  <= req_d;
      ack_q  <= access;
      dat_q  <= dat_d;
    end
  end

  assign irq_req_o = req_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

`default_nettype wire
